// File: rtl/dmem_arbiter_if.sv
// Bus bundle for the data-memory arbiter: core port, debug port and
// the single-port memory side, viewed from the arbiter (slave) or its peers.
interface dmem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              core_req;
   logic              core_we;
   logic [ADDR_W-1:0] core_addr;
   logic [DATA_W-1:0] core_wdata;
   logic [DATA_W-1:0] core_rdata;
   logic              core_done;
   logic              core_stall;

   logic              dbg_req;
   logic              dbg_we;
   logic [ADDR_W-1:0] dbg_addr;
   logic [DATA_W-1:0] dbg_wdata;
   logic [DATA_W-1:0] dbg_rdata;
   logic              dbg_ack;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   logic              busy;
   logic              grant_owner;

   modport slave (
      input  core_req, core_we, core_addr, core_wdata,
      input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
      input  mem_rdata,
      output core_rdata, core_done, core_stall,
      output dbg_rdata, dbg_ack,
      output mem_en, mem_we, mem_addr, mem_wdata,
      output busy, grant_owner
   );

   modport master (
      output core_req, core_we, core_addr, core_wdata,
      output dbg_req, dbg_we, dbg_addr, dbg_wdata,
      output mem_rdata,
      input  core_rdata, core_done, core_stall,
      input  dbg_rdata, dbg_ack,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      input  busy, grant_owner
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares one single-port synchronous data memory between the core
// load/store port and a debug/loader port; debug has priority.
module dmem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MEM_LAT    = 1,
   parameter int STARVE_MAX = 8
) (
   input logic          clk,
   input logic          reset,
   dmem_arbiter_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      WAIT,
      DONE
   } state_e;

   localparam logic [1:0] LAT_M1     = 2'(MEM_LAT - 1);
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   state_e            state_q, state_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [3:0]        starve_q, starve_d;
   logic              we_q, we_d;
   logic              owner_q, owner_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] core_rdata_q, core_rdata_d;
   logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;

   logic grant_dbg;
   logic grant_core;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      starve_d     = starve_q;
      we_d         = we_q;
      owner_d      = owner_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      core_rdata_d = core_rdata_q;
      dbg_rdata_d  = dbg_rdata_q;

      // starvation guard: core wins once it has lost STARVE_MAX times
      grant_dbg  = bus.dbg_req && (starve_q < STARVE_LIM);
      grant_core = !grant_dbg && bus.core_req;

      unique case (state_q)
         IDLE: begin
            if (!bus.core_req) starve_d = '0;
            if (grant_dbg || grant_core) begin
               state_d = ACCESS;
               owner_d = grant_dbg;
               we_d    = grant_dbg ? bus.dbg_we    : bus.core_we;
               addr_d  = grant_dbg ? bus.dbg_addr  : bus.core_addr;
               wdata_d = grant_dbg ? bus.dbg_wdata : bus.core_wdata;
               if (grant_core) begin
                  starve_d = '0;
               end else if (bus.core_req && starve_q != 4'hF) begin
                  starve_d = starve_q + 4'd1;
               end
            end
         end
         ACCESS: begin
            state_d = we_q ? DONE : WAIT;
            cnt_d   = '0;
         end
         WAIT: begin
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == LAT_M1) begin
               state_d = DONE;
               if (owner_q) dbg_rdata_d  = bus.mem_rdata;
               else         core_rdata_d = bus.mem_rdata;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         starve_q     <= '0;
         we_q         <= 1'b0;
         owner_q      <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         core_rdata_q <= '0;
         dbg_rdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         starve_q     <= starve_d;
         we_q         <= we_d;
         owner_q      <= owner_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         core_rdata_q <= core_rdata_d;
         dbg_rdata_q  <= dbg_rdata_d;
      end
   end

   assign bus.mem_en      = (state_q == ACCESS);
   assign bus.mem_we      = (state_q == ACCESS) && we_q;
   assign bus.mem_addr    = addr_q;
   assign bus.mem_wdata   = wdata_q;
   assign bus.core_done   = (state_q == DONE) && !owner_q;
   assign bus.dbg_ack     = (state_q == DONE) && owner_q;
   assign bus.core_rdata  = core_rdata_q;
   assign bus.dbg_rdata   = dbg_rdata_q;
   assign bus.busy        = (state_q != IDLE);
   assign bus.grant_owner = owner_q;
   assign bus.core_stall  = bus.core_req &&
                            !((state_q == DONE) && !owner_q);
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: two instances (MEM_LAT=1 and
// MEM_LAT=3/STARVE_MAX=2), each with a latency-exact memory model.
module tb_dmem_arbiter;
   localparam int LA = 1;
   localparam int LB = 3;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_fail = 0;

   typedef struct {
      bit          rd;
      logic [31:0] data;
      int          due;
   } sb_t;
   sb_t exp_q[4][$];

   logic        cq[2], cw[2], dq[2], dw[2];
   logic [31:0] ca[2], cd[2], da[2], dd[2];

   dmem_arbiter_if ia ();
   dmem_arbiter_if ib ();

   assign ia.core_req   = cq[0];
   assign ia.core_we    = cw[0];
   assign ia.core_addr  = ca[0];
   assign ia.core_wdata = cd[0];
   assign ia.dbg_req    = dq[0];
   assign ia.dbg_we     = dw[0];
   assign ia.dbg_addr   = da[0];
   assign ia.dbg_wdata  = dd[0];
   assign ib.core_req   = cq[1];
   assign ib.core_we    = cw[1];
   assign ib.core_addr  = ca[1];
   assign ib.core_wdata = cd[1];
   assign ib.dbg_req    = dq[1];
   assign ib.dbg_we     = dw[1];
   assign ib.dbg_addr   = da[1];
   assign ib.dbg_wdata  = dd[1];

   dmem_arbiter #(.MEM_LAT(LA)) u_a (
      .clk(clk), .reset(reset), .bus(ia)
   );
   dmem_arbiter #(.MEM_LAT(LB), .STARVE_MAX(2)) u_b (
      .clk(clk), .reset(reset), .bus(ib)
   );

   function automatic logic [31:0] init_val(input int i);
      return 32'hC0DE_0000 + 32'(i);
   endfunction

   // read data is only valid exactly LAT cycles after the mem_en cycle
   logic [31:0]      mem_a[16], mem_b[16];
   logic [3:0]       pva, pvb;
   logic [3:0][31:0] pda, pdb;

   always @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < 16; i++) mem_a[i] <= init_val(i);
         pva <= '0;
      end else begin
         if (ia.mem_en && ia.mem_we) mem_a[ia.mem_addr[5:2]] <= ia.mem_wdata;
         pva <= {pva[2:0], ia.mem_en & ~ia.mem_we};
         pda <= {pda[2:0], mem_a[ia.mem_addr[5:2]]};
      end
   end

   always @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < 16; i++) mem_b[i] <= init_val(i);
         pvb <= '0;
      end else begin
         if (ib.mem_en && ib.mem_we) mem_b[ib.mem_addr[5:2]] <= ib.mem_wdata;
         pvb <= {pvb[2:0], ib.mem_en & ~ib.mem_we};
         pdb <= {pdb[2:0], mem_b[ib.mem_addr[5:2]]};
      end
   end

   assign ia.mem_rdata = pva[LA-1] ? pda[LA-1] : 32'hBADB_AD00;
   assign ib.mem_rdata = pvb[LB-1] ? pdb[LB-1] : 32'hBADB_AD00;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)",
                  tag, got, exp, cyc);
      end
   endtask

   task automatic sb_push(input int idx, input bit rd,
                          input logic [31:0] data, input int due);
      sb_t e;
      e.rd   = rd;
      e.data = data;
      e.due  = due;
      exp_q[idx].push_back(e);
   endtask

   task automatic sb_pop(input int idx, input logic [31:0] rdata);
      sb_t e;
      if (exp_q[idx].size() == 0) begin
         chk($sformatf("sb_unexp%0d", idx), 32'(exp_q[idx].size()), 32'd1);
      end else begin
         e = exp_q[idx].pop_front();
         chk($sformatf("sb_cyc%0d", idx), cyc, e.due);
         if (e.rd) chk($sformatf("sb_rdata%0d", idx), rdata, e.data);
      end
   endtask

   always @(negedge clk) begin
      if (ia.core_done === 1'b1) sb_pop(0, ia.core_rdata);
      if (ia.dbg_ack === 1'b1)   sb_pop(1, ia.dbg_rdata);
      if (ib.core_done === 1'b1) sb_pop(2, ib.core_rdata);
      if (ib.dbg_ack === 1'b1)   sb_pop(3, ib.dbg_rdata);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int t;
      for (int i = 0; i < 2; i++) begin
         cq[i] = 0; cw[i] = 0; ca[i] = '0; cd[i] = '0;
         dq[i] = 0; dw[i] = 0; da[i] = '0; dd[i] = '0;
      end
      reset = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      chk("rst_busy",   32'(ia.busy), 0);
      chk("rst_en",     32'(ia.mem_en), 0);
      chk("rst_we",     32'(ia.mem_we), 0);
      chk("rst_addr",   ia.mem_addr, 0);
      chk("rst_wdata",  ia.mem_wdata, 0);
      chk("rst_crd",    ia.core_rdata, 0);
      chk("rst_drd",    ia.dbg_rdata, 0);
      chk("rst_done",   32'(ia.core_done), 0);
      chk("rst_ack",    32'(ia.dbg_ack), 0);
      chk("rst_owner",  32'(ia.grant_owner), 0);
      chk("rst_stall",  32'(ia.core_stall), 0);
      chk("rst_b_busy", 32'(ib.busy), 0);
      tick();
      reset = 1'b1;
      tick();

      // core store, MEM_LAT=1
      t = cyc;
      cq[0] = 1; cw[0] = 1; ca[0] = 32'h10; cd[0] = 32'hDEADBEEF;
      sb_push(0, 0, '0, t + 2);
      @(negedge clk);
      chk("t1_stall_t0", 32'(ia.core_stall), 1);
      chk("t1_en_t0",    32'(ia.mem_en), 0);
      tick();
      @(negedge clk);
      chk("t1_en_t1",    32'(ia.mem_en), 1);
      chk("t1_we_t1",    32'(ia.mem_we), 1);
      chk("t1_addr",     ia.mem_addr, 32'h10);
      chk("t1_wdata",    ia.mem_wdata, 32'hDEADBEEF);
      chk("t1_stall_t1", 32'(ia.core_stall), 1);
      chk("t1_busy",     32'(ia.busy), 1);
      tick();
      @(negedge clk);
      chk("t1_stall_t2", 32'(ia.core_stall), 0);
      tick();
      cq[0] = 0; cw[0] = 0;
      tick();

      // core load of the stored word
      t = cyc;
      cq[0] = 1; ca[0] = 32'h10;
      sb_push(0, 1, 32'hDEADBEEF, t + 3);
      repeat (3) tick();
      @(negedge clk);
      chk("t2_stall_done", 32'(ia.core_stall), 0);
      tick();
      cq[0] = 0;
      @(negedge clk);
      chk("t2_crd_hold", ia.core_rdata, 32'hDEADBEEF);
      chk("t2_drd_keep", ia.dbg_rdata, 0);
      tick();

      // simultaneous core and debug reads
      t = cyc;
      cq[0] = 1; ca[0] = 32'h14;
      dq[0] = 1; dw[0] = 0; da[0] = 32'h18;
      sb_push(1, 1, init_val(6), t + 3);
      sb_push(0, 1, init_val(5), t + 7);
      @(negedge clk);
      chk("t3_stall_t0", 32'(ia.core_stall), 1);
      tick();
      @(negedge clk);
      chk("t3_owner_dbg", 32'(ia.grant_owner), 1);
      chk("t3_addr_dbg",  ia.mem_addr, 32'h18);
      repeat (2) tick();
      @(negedge clk);
      chk("t3_stall_dbgdone", 32'(ia.core_stall), 1);
      tick();
      dq[0] = 0;
      tick();
      @(negedge clk);
      chk("t3_owner_core", 32'(ia.grant_owner), 0);
      chk("t3_addr_core",  ia.mem_addr, 32'h14);
      chk("t3_en_core",    32'(ia.mem_en), 1);
      repeat (3) tick();
      cq[0] = 0;
      @(negedge clk);
      chk("t3_crd", ia.core_rdata, init_val(5));
      chk("t3_drd", ia.dbg_rdata, init_val(6));
      tick();

      // starvation guard, STARVE_MAX=2, MEM_LAT=3
      t = cyc;
      cq[1] = 1; cw[1] = 0; ca[1] = 32'h20;
      dq[1] = 1; dw[1] = 0; da[1] = 32'h24;
      sb_push(3, 1, init_val(9), t + 5);
      sb_push(3, 1, init_val(9), t + 11);
      sb_push(2, 1, init_val(8), t + 17);
      sb_push(3, 1, init_val(9), t + 23);
      sb_push(2, 1, init_val(8), t + 29);
      for (int k = 0; k < 31; k++) begin
         if (k == 24) dq[1] = 0;
         if (k == 30) cq[1] = 0;
         @(negedge clk);
         if (k == 1 || k == 7 || k == 19)
            chk($sformatf("t4_owner_dbg_k%0d", k), 32'(ib.grant_owner), 1);
         if (k == 13 || k == 25)
            chk($sformatf("t4_owner_core_k%0d", k), 32'(ib.grant_owner), 0);
         tick();
      end

      // core load with MEM_LAT=3
      t = cyc;
      cq[1] = 1; ca[1] = 32'h2C;
      sb_push(2, 1, init_val(11), t + 5);
      for (int k = 0; k < 7; k++) begin
         if (k == 6) cq[1] = 0;
         @(negedge clk);
         if (k == 1) chk("t5_en_t1", 32'(ib.mem_en), 1);
         if (k >= 2 && k <= 4)
            chk($sformatf("t5_en_k%0d", k), 32'(ib.mem_en), 0);
         if (k == 4) chk("t5_crd_old", ib.core_rdata, init_val(8));
         if (k == 5) chk("t5_stall_done", 32'(ib.core_stall), 0);
         if (k == 6) begin
            chk("t5_crd_new", ib.core_rdata, init_val(11));
            chk("t5_drd_keep", ib.dbg_rdata, init_val(9));
         end
         tick();
      end

      // reset in the middle of a read, request held across it
      t = cyc;
      cq[1] = 1; ca[1] = 32'h30;
      for (int k = 0; k < 12; k++) begin
         if (k == 3) reset = 1'b0;
         if (k == 5) begin
            reset = 1'b1;
            sb_push(2, 1, init_val(12), t + 10);
         end
         if (k == 11) cq[1] = 0;
         @(negedge clk);
         if (k == 2) chk("t6_busy_wait", 32'(ib.busy), 1);
         if (k == 4) begin
            chk("t6_busy_rst", 32'(ib.busy), 0);
            chk("t6_en_rst",   32'(ib.mem_en), 0);
            chk("t6_done_rst", 32'(ib.core_done), 0);
            chk("t6_crd_rst",  ib.core_rdata, 0);
         end
         if (k == 5) chk("t6_en_rel", 32'(ib.mem_en), 0);
         if (k == 6) begin
            chk("t6_en_again", 32'(ib.mem_en), 1);
            chk("t6_addr",     ib.mem_addr, 32'h30);
         end
         tick();
      end

      repeat (4) tick();
      for (int i = 0; i < 4; i++)
         chk($sformatf("sb_left%0d", i), 32'(exp_q[i].size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
